rx_iq_buffer: RTL and testbench
===============================

Name: rx_iq_buffer

Overview:
Show-ahead FIFO between the DDC output (RX1/RX2 decimated I/Q) and the STM32 parallel-bus interface. It captures one 4×24-bit IQ frame per DDC valid strobe and presents the head frame to the bus interface. It pops a frame on each IQ_RX_READ_CLK rising edge while IQ_RX_READ_REQ is high. It reports empty, fill level and sticky overrun/underrun flags. Single clock domain, clk_in; the DDC output is already retimed into clk_in.

Parameters:
DEPTH_LOG2, 5, FIFO depth = 2**DEPTH_LOG2 frames (32)
IQ_WIDTH, 24, width of each I or Q sample

Ports:
clk_in  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
iq_valid  in  1  one-cycle strobe: new frame on RX*_in
RX1_I_in  in  IQ_WIDTH  RX1 I sample, signed
RX1_Q_in  in  IQ_WIDTH  RX1 Q sample, signed
RX2_I_in  in  IQ_WIDTH  RX2 I sample, signed
RX2_Q_in  in  IQ_WIDTH  RX2 Q sample, signed
IQ_RX_READ_REQ  in  1  bus interface is streaming RX IQ (level)
IQ_RX_READ_CLK  in  1  pop request; acts on rising edge only
flush  in  1  synchronous clear of FIFO contents (level, from sync_reset_rx_n inverted)
clear_flags  in  1  one-cycle pulse; clears sticky flags
RX1_I  out  IQ_WIDTH  head frame RX1 I
RX1_Q  out  IQ_WIDTH  head frame RX1 Q
RX2_I  out  IQ_WIDTH  head frame RX2 I
RX2_Q  out  IQ_WIDTH  head frame RX2 Q
in_empty  out  1  FIFO holds no frame
fill_level  out  DEPTH_LOG2+1  frames stored, 0..DEPTH
iq_overrun  out  1  sticky: frame dropped because FIFO full
iq_underrun  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, reset_n=0):
  - wr_ptr, rd_ptr and count are 0; in_empty=1; fill_level=0; flags=0.
  - RX1_I, RX1_Q, RX2_I and RX2_Q outputs are 0.
  - read_clk_d (previous IQ_RX_READ_CLK) is 0.
- Pop event: pop = IQ_RX_READ_REQ & IQ_RX_READ_CLK & ~read_clk_d. read_clk_d is registered every cycle.
- Write: on iq_valid with count<DEPTH, store {RX1_I_in,RX1_Q_in,RX2_I_in,RX2_Q_in} at wr_ptr and increment wr_ptr (mod DEPTH).
- Pop: with count>0, increment rd_ptr (mod DEPTH).
- Count update uses the pre-edge count:
  - write only: +1
  - pop only: −1
  - write and pop both valid: unchanged
- Simultaneous write and pop when full: the pop frees a slot, so the write is accepted and no overrun is flagged.
- Simultaneous write and pop when empty: the pop is an underrun and is ignored; the write is accepted; count becomes 1.
- Full + iq_valid without pop: frame dropped, pointers unchanged, iq_overrun←1.
- Empty + pop: no pointer change; outputs hold the last value; iq_underrun←1.
- Show-ahead outputs:
  - Outputs are registered and equal the frame at rd_ptr whenever count>0.
  - They are updated on the same edge that changes rd_ptr or that writes into an empty FIFO. The new head is therefore visible together with in_empty=0 one edge after the iq_valid cycle.
  - The bus interface samples the head on the edge following its READ_CLK rise. That is the same edge that pops, so it always captures the pre-pop head.
- in_empty = (count==0), registered alongside count. fill_level = count.
- flush=1: pointers and count go to 0, in_empty=1, and writes are ignored while flush is high. Outputs and flags are retained. If flush is released mid-stream, the next write starts at slot 0.
- clear_flags: clears both flags. A same-cycle overrun/underrun event wins (flag stays 1).
- Pointer wrap: DEPTH_LOG2-bit pointers wrap naturally. count is DEPTH_LOG2+1 bits so full (count==DEPTH) is unambiguous.
- No arithmetic on sample data; samples pass through bit-exact.

Decomposition:
- Shared package (rx_iq_pkg): IQ_WIDTH; FRAME_WIDTH=4*IQ_WIDTH; frame field offsets (RX1_I msb..RX2_Q lsb); default DEPTH_LOG2.
- One sub-module, iq_frame_ram: simple dual-port DEPTH×FRAME_WIDTH storage, synchronous write, asynchronous read of rd_ptr. The top block holds the pointers, count, output registers, edge detect and flags.

Test Plan:
- Reset then write 3 frames (RX1_I=0x000001/2/3, others distinct) with no pops -> in_empty=0 after the first frame's edge+1; fill_level=3; RX1_I=0x000001.
- Toggle READ_CLK with READ_REQ=1 three times (1 cycle high, 1 low) -> pre-pop heads captured as 0x000001, 0x000002, 0x000003; in_empty=1 after the third pop; iq_underrun=0.
- Hold READ_CLK high for 4 cycles with 2 frames stored -> exactly one pop; fill_level 2→1.
- Write 33 frames, no pops -> fill_level=32; 33rd frame dropped; iq_overrun=1. Then write and pop on the same cycle while full -> fill_level stays 32, no new overrun. clear_flags -> iq_overrun=0.
- Pop while empty -> iq_underrun=1, outputs unchanged. Pop and write on the same cycle while empty -> fill_level=1; the written frame appears on the outputs.
- 5 frames stored, assert flush for 2 cycles with iq_valid active -> fill_level=0, in_empty=1. Release flush and write 0xABCDEF -> RX1_I=0xABCDEF. Assert reset_n=0 mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_iq_pkg.sv
// Shared constants for the RX IQ show-ahead buffer: sample/frame widths,
// frame field offsets and the default FIFO depth.
package rx_iq_pkg;

  localparam int IQ_WIDTH           = 24;
  localparam int FRAME_WIDTH        = 4 * IQ_WIDTH;
  localparam int DEPTH_LOG2_DEFAULT = 5;

  // Frame layout, most significant field first: RX1_I, RX1_Q, RX2_I, RX2_Q
  localparam int RX1_I_MSB = FRAME_WIDTH - 1;
  localparam int RX1_I_LSB = 3 * IQ_WIDTH;
  localparam int RX1_Q_MSB = 3 * IQ_WIDTH - 1;
  localparam int RX1_Q_LSB = 2 * IQ_WIDTH;
  localparam int RX2_I_MSB = 2 * IQ_WIDTH - 1;
  localparam int RX2_I_LSB = IQ_WIDTH;
  localparam int RX2_Q_MSB = IQ_WIDTH - 1;
  localparam int RX2_Q_LSB = 0;

endpackage

// File: rtl/iq_frame_ram.sv
// Simple dual-port frame storage: synchronous write, asynchronous read.
module iq_frame_ram #(
  parameter int DEPTH_LOG2 = 5,
  parameter int WIDTH      = 96
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Frame write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/rx_iq_buffer.sv
// Show-ahead FIFO of 4x IQ frames between the DDC and the parallel-bus reader.
// The head frame is held in output registers so the reader sees it with no read latency.
module rx_iq_buffer #(
  parameter int DEPTH_LOG2 = rx_iq_pkg::DEPTH_LOG2_DEFAULT,
  parameter int IQ_WIDTH   = rx_iq_pkg::IQ_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  iq_valid,
  input  logic [IQ_WIDTH-1:0]   RX1_I_in,
  input  logic [IQ_WIDTH-1:0]   RX1_Q_in,
  input  logic [IQ_WIDTH-1:0]   RX2_I_in,
  input  logic [IQ_WIDTH-1:0]   RX2_Q_in,
  input  logic                  IQ_RX_READ_REQ,
  input  logic                  IQ_RX_READ_CLK,
  input  logic                  flush,
  input  logic                  clear_flags,
  output logic [IQ_WIDTH-1:0]   RX1_I,
  output logic [IQ_WIDTH-1:0]   RX1_Q,
  output logic [IQ_WIDTH-1:0]   RX2_I,
  output logic [IQ_WIDTH-1:0]   RX2_Q,
  output logic                  in_empty,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  iq_overrun,
  output logic                  iq_underrun
);

  import rx_iq_pkg::*;

  localparam int FW    = 4 * IQ_WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = '0;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [FW-1:0]         FRAME_ZERO = '0;

  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  empty_r;
  logic                  read_clk_d_r;
  logic [FW-1:0]         head_r;
  logic                  overrun_r;
  logic                  underrun_r;

  logic [FW-1:0]         in_frame_s;
  logic [FW-1:0]         ram_rd_data_s;
  logic [DEPTH_LOG2-1:0] ram_rd_addr_s;
  logic                  pop_req_s;
  logic                  is_empty_s;
  logic                  is_full_s;
  logic                  pop_ok_s;
  logic                  wr_ok_s;
  logic                  overrun_evt_s;
  logic                  underrun_evt_s;
  logic                  load_in_s;
  logic                  load_ram_s;
  logic [DEPTH_LOG2:0]   count_next_s;

  assign in_frame_s = {RX1_I_in, RX1_Q_in, RX2_I_in, RX2_Q_in};

  // The RAM is read one slot ahead of the head: that frame becomes the head on a pop.
  assign ram_rd_addr_s = rd_ptr_r + PTR_ONE;

  iq_frame_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (FW)
  ) u_ram (
    .clk     (clk_in),
    .we      (wr_ok_s),
    .wr_addr (wr_ptr_r),
    .wr_data (in_frame_s),
    .rd_addr (ram_rd_addr_s),
    .rd_data (ram_rd_data_s)
  );

  // Pop/write qualification, flag events and next fill count
  always_comb begin
    pop_req_s      = IQ_RX_READ_REQ & IQ_RX_READ_CLK & ~read_clk_d_r;
    is_empty_s     = (count_r == CNT_ZERO);
    is_full_s      = (count_r == CNT_FULL);
    pop_ok_s       = pop_req_s & ~is_empty_s & ~flush;
    // A pop on a full FIFO frees the slot the write lands in.
    wr_ok_s        = iq_valid & ~flush & (~is_full_s | pop_ok_s);
    overrun_evt_s  = iq_valid & ~flush & is_full_s & ~pop_ok_s;
    underrun_evt_s = pop_req_s & is_empty_s & ~flush;
    // Head comes straight from the input when the written frame is the new head.
    load_in_s      = wr_ok_s & (is_empty_s | ((count_r == CNT_ONE) & pop_ok_s));
    load_ram_s     = pop_ok_s & (count_r > CNT_ONE);
    case ({wr_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // READ_CLK edge-detect history
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      read_clk_d_r <= 1'b0;
    end else begin
      read_clk_d_r <= IQ_RX_READ_CLK;
    end
  end

  // Pointers, fill count and empty flag
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      empty_r  <= 1'b1;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      empty_r  <= 1'b1;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == CNT_ZERO);
    end
  end

  // Show-ahead head register; holds its value when the FIFO drains or is flushed
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      head_r <= FRAME_ZERO;
    end else if (load_in_s) begin
      head_r <= in_frame_s;
    end else if (load_ram_s) begin
      head_r <= ram_rd_data_s;
    end
  end

  // Sticky error flags; a same-cycle event beats clear_flags
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (overrun_evt_s) begin
        overrun_r <= 1'b1;
      end else if (clear_flags) begin
        overrun_r <= 1'b0;
      end
      if (underrun_evt_s) begin
        underrun_r <= 1'b1;
      end else if (clear_flags) begin
        underrun_r <= 1'b0;
      end
    end
  end

  assign RX1_I       = head_r[4*IQ_WIDTH-1:3*IQ_WIDTH];
  assign RX1_Q       = head_r[3*IQ_WIDTH-1:2*IQ_WIDTH];
  assign RX2_I       = head_r[2*IQ_WIDTH-1:IQ_WIDTH];
  assign RX2_Q       = head_r[IQ_WIDTH-1:0];
  assign in_empty    = empty_r;
  assign fill_level  = count_r;
  assign iq_overrun  = overrun_r;
  assign iq_underrun = underrun_r;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Self-checking bench for rx_iq_buffer: directed scenarios plus a random phase,
// compared against a queue-based model of the FIFO.
module tb_rx_iq_buffer;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        iq_valid;
  logic [23:0] RX1_I_in, RX1_Q_in, RX2_I_in, RX2_Q_in;
  logic        IQ_RX_READ_REQ, IQ_RX_READ_CLK, flush, clear_flags;
  logic [23:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic        in_empty;
  logic [5:0]  fill_level;
  logic        iq_overrun, iq_underrun;

  int errors = 0;
  int checks = 0;

  logic [95:0] mq[$];
  logic [95:0] m_head;
  logic        m_ov, m_un, m_prev;

  rx_iq_buffer dut (
    .clk_in(clk_in), .reset_n(reset_n), .iq_valid(iq_valid),
    .RX1_I_in(RX1_I_in), .RX1_Q_in(RX1_Q_in), .RX2_I_in(RX2_I_in), .RX2_Q_in(RX2_Q_in),
    .IQ_RX_READ_REQ(IQ_RX_READ_REQ), .IQ_RX_READ_CLK(IQ_RX_READ_CLK),
    .flush(flush), .clear_flags(clear_flags),
    .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
    .in_empty(in_empty), .fill_level(fill_level),
    .iq_overrun(iq_overrun), .iq_underrun(iq_underrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] mk(input int n);
    logic [23:0] a, b, c, d;
    a = 24'(n);
    b = 24'(n + 32'h100);
    c = 24'(n + 32'h20000);
    d = 24'(n + 32'h300000);
    return {a, b, c, d};
  endfunction

  function automatic logic [95:0] rnd_frame();
    logic [23:0] a, b, c, d;
    a = 24'($urandom);
    b = 24'($urandom);
    c = 24'($urandom);
    d = 24'($urandom);
    return {a, b, c, d};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_head = '0;
    m_ov   = 1'b0;
    m_un   = 1'b0;
    m_prev = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [95:0] obs_head;
    logic        exp_empty;
    obs_head  = {RX1_I, RX1_Q, RX2_I, RX2_Q};
    exp_empty = (mq.size() == 0);
    chk({tag, ".head"}, obs_head, m_head);
    chk({tag, ".in_empty"}, 96'(in_empty), 96'(exp_empty));
    chk({tag, ".fill_level"}, 96'(fill_level), 96'(mq.size()));
    chk({tag, ".iq_overrun"}, 96'(iq_overrun), 96'(m_ov));
    chk({tag, ".iq_underrun"}, 96'(iq_underrun), 96'(m_un));
  endtask

  // One clock: apply inputs, advance the model by FIFO rules, compare everything.
  task automatic step(input string tag, input logic v, input logic [95:0] f,
                      input logic req, input logic rc, input logic fl, input logic clr);
    bit pop, popped, ov, un;
    int had;
    iq_valid = v;
    {RX1_I_in, RX1_Q_in, RX2_I_in, RX2_Q_in} = f;
    IQ_RX_READ_REQ = req;
    IQ_RX_READ_CLK = rc;
    flush = fl;
    clear_flags = clr;
    @(posedge clk_in);
    #1;
    pop = req && rc && !m_prev;
    m_prev = rc;
    popped = 0; ov = 0; un = 0;
    if (fl) begin
      mq.delete();
    end else begin
      had = mq.size();
      if (pop) begin
        if (had > 0) begin
          void'(mq.pop_front());
          popped = 1;
        end else begin
          un = 1;
        end
      end
      if (v) begin
        if (had < 32 || popped) mq.push_back(f);
        else ov = 1;
      end
      if (mq.size() > 0) m_head = mq[0];
    end
    if (ov) m_ov = 1'b1; else if (clr) m_ov = 1'b0;
    if (un) m_un = 1'b1; else if (clr) m_un = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [95:0] saved;
    logic [95:0] fr;
    reset_n = 1'b0;
    iq_valid = 1'b0; flush = 1'b0; clear_flags = 1'b0;
    IQ_RX_READ_REQ = 1'b0; IQ_RX_READ_CLK = 1'b0;
    {RX1_I_in, RX1_Q_in, RX2_I_in, RX2_Q_in} = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // Three writes, no pops
    step("wr1", 1'b1, mk(1), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wr1.nonempty", 96'(in_empty), 96'(1'b0));
    chk("wr1.rx1_i", 96'(RX1_I), 96'(24'h000001));
    step("wr2", 1'b1, mk(2), 1'b0, 1'b0, 1'b0, 1'b0);
    step("wr3", 1'b1, mk(3), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wr3.fill", 96'(fill_level), 96'(6'd3));

    // Three READ_CLK pulses: each pre-pop head is seen before its edge
    for (int i = 1; i <= 3; i++) begin
      chk("prepop.rx1_i", 96'(RX1_I), 96'(i));
      step("pop_hi", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      step("pop_lo", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("drained.in_empty", 96'(in_empty), 96'(1'b1));
    chk("drained.underrun", 96'(iq_underrun), 96'(1'b0));

    // READ_CLK held high for 4 cycles pops once
    step("two_a", 1'b1, mk(4), 1'b1, 1'b0, 1'b0, 1'b0);
    step("two_b", 1'b1, mk(5), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hold.fill_before", 96'(fill_level), 96'(6'd2));
    for (int i = 0; i < 4; i++) step("hold_hi", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold.fill_after", 96'(fill_level), 96'(6'd1));
    step("hold_lo", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("empty_hi", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("empty_lo", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overfill by one
    for (int i = 0; i < 33; i++) step("fill", 1'b1, mk(16 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full.fill", 96'(fill_level), 96'(6'd32));
    chk("full.overrun", 96'(iq_overrun), 96'(1'b1));
    step("full_wrpop", 1'b1, mk(100), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("full_wrpop.fill", 96'(fill_level), 96'(6'd32));
    step("full_lo", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("clear", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clear.overrun", 96'(iq_overrun), 96'(1'b0));
    step("full_wrpop2", 1'b1, mk(101), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("full_wrpop2.overrun", 96'(iq_overrun), 96'(1'b0));
    chk("full_wrpop2.fill", 96'(fill_level), 96'(6'd32));

    // Drain, then underrun cases
    for (int i = 0; i < 32; i++) begin
      step("drain_lo", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("drain_hi", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    step("drain_end", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    saved = {RX1_I, RX1_Q, RX2_I, RX2_Q};
    step("underrun", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("underrun.flag", 96'(iq_underrun), 96'(1'b1));
    chk("underrun.hold", {RX1_I, RX1_Q, RX2_I, RX2_Q}, saved);
    step("un_lo", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    fr = mk(24'h5A5A5);
    step("un_wrpop", 1'b1, fr, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("un_wrpop.fill", 96'(fill_level), 96'(6'd1));
    chk("un_wrpop.head", {RX1_I, RX1_Q, RX2_I, RX2_Q}, fr);
    step("un_wrpop_lo", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Flush with writes pending, then restart
    for (int i = 0; i < 4; i++) step("pre_flush", 1'b1, mk(200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_flush.fill", 96'(fill_level), 96'(6'd5));
    step("flush1", 1'b1, mk(300), 1'b0, 1'b0, 1'b1, 1'b0);
    step("flush2", 1'b1, mk(301), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush.fill", 96'(fill_level), 96'(6'd0));
    chk("flush.in_empty", 96'(in_empty), 96'(1'b1));
    fr = {24'hABCDEF, 24'h123456, 24'h654321, 24'hFEDCBA};
    step("post_flush", 1'b1, fr, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_flush.rx1_i", 96'(RX1_I), 96'(24'hABCDEF));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 99) < 55), rnd_frame(),
           ($urandom_range(0, 9) != 0), 1'($urandom), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, rnd_frame(), 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk_in);
    reset_n = 1'b1;
    step("after_rst", 1'b1, mk(7), 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
